io_port_controller: RTL and testbench



---
 rtl/io_pkg.sv | 19 +
 rtl/input_debouncer.sv | 93 +++++++++
 rtl/io_port_controller.sv | 101 ++++++++++
 tb/tb_io_port_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO port controller.
//   - Byte offsets of the three register words relative to IO_BASE
//   - Bit positions inside the STATUS word
//   - Debounce FSM state type
package io_pkg;

   localparam logic [31:0] OFFSET_OUT    = 32'd0;
   localparam logic [31:0] OFFSET_IN     = 32'd4;
   localparam logic [31:0] OFFSET_STATUS = 32'd8;

   localparam int unsigned STATUS_CHANGED_BIT = 0;
   localparam int unsigned STATUS_BUSY_BIT    = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } debounceState_t;

endpackage : io_pkg

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a debounce FSM for an 8-bit input bus.
// A new synchronised value must hold for DEBOUNCE_CYCLES consecutive cycles
// before it is committed to 'stable'.
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-low reset
//   din     in   8-bit asynchronous input pins
//   stable  out  debounced value
//   commit  out  high in the cycle whose closing edge updates 'stable'
//   busy    out  FSM is in COUNT (a candidate value is being qualified)
module input_debouncer
   import io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] din,
   output logic [7:0] stable,
   output logic       commit,
   output logic       busy
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [7:0]       sync1;
   logic [7:0]       sync2;
   logic [7:0]       candidate;
   logic [CNT_W-1:0] cnt;
   debounceState_t   state;

   logic [7:0]       candidateNext;
   logic [CNT_W-1:0] cntNext;
   logic [7:0]       stableNext;
   debounceState_t   stateNext;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1     <= '0;
         sync2     <= '0;
         candidate <= '0;
         cnt       <= '0;
         stable    <= '0;
         state     <= IDLE;
      end else begin
         sync1     <= din;
         sync2     <= sync1;
         candidate <= candidateNext;
         cnt       <= cntNext;
         stable    <= stableNext;
         state     <= stateNext;
      end
   end

   always_comb begin
      stateNext     = state;
      candidateNext = candidate;
      cntNext       = cnt;
      stableNext    = stable;
      commit        = 1'b0;
      case (state)
         IDLE: begin
            if (sync2 != stable) begin
               candidateNext = sync2;
               cntNext       = '0;
               stateNext     = COUNT;
            end
         end
         COUNT: begin
            if (sync2 == candidate) begin
               if (cnt == CNT_LAST) begin
                  stableNext = candidate;
                  commit     = 1'b1;
                  stateNext  = IDLE;
               end else begin
                  cntNext = cnt + CNT_W'(1);
               end
            end else if (sync2 == stable) begin
               // Input bounced back to the committed value: drop the candidate.
               stateNext = IDLE;
            end else begin
               candidateNext = sync2;
               cntNext       = '0;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign busy = (state == COUNT);

endmodule : input_debouncer

// File: rtl/io_port_controller.sv
// Memory-mapped IO stage behind the single-cycle MIPS datapath.
// Three-word window at IO_BASE: OUT (+0, R/W), IN (+4, R), STATUS (+8, R,
// reading clears the sticky 'changed' bit).
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   Address    in   byte address from the ALU result
//   WriteData  in   store data (rt register)
//   MemWrite   in   store strobe
//   MemRead    in   load strobe
//   PortIn     in   8-bit asynchronous input pins
//   ReadData   out  combinational load data for the MemtoReg mux
//   IOHit      out  Address falls inside the IO window
//   PortOut    out  registered 32-bit output port
module io_port_controller
   import io_pkg::*;
#(
   parameter logic [31:0] IO_BASE         = 32'h1001_0024,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [7:0]  PortIn,
   output logic [31:0] ReadData,
   output logic        IOHit,
   output logic [31:0] PortOut
);

   localparam logic [31:0] ADDR_OUT    = IO_BASE + OFFSET_OUT;
   localparam logic [31:0] ADDR_IN     = IO_BASE + OFFSET_IN;
   localparam logic [31:0] ADDR_STATUS = IO_BASE + OFFSET_STATUS;

   logic       hitOut;
   logic       hitIn;
   logic       hitStatus;
   logic       changed;
   logic       commit;
   logic       busy;
   logic [7:0] stable;
   logic [31:0] statusWord;
   logic       unusedAddrBits;

   input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) uDebouncer (
      .clk   (clk),
      .reset (reset),
      .din   (PortIn),
      .stable(stable),
      .commit(commit),
      .busy  (busy)
   );

   // Byte lane bits are irrelevant: the window is decoded on word addresses.
   assign unusedAddrBits = ^Address[1:0];
   assign hitOut    = (Address[31:2] == ADDR_OUT[31:2]);
   assign hitIn     = (Address[31:2] == ADDR_IN[31:2]);
   assign hitStatus = (Address[31:2] == ADDR_STATUS[31:2]);
   assign IOHit     = hitOut | hitIn | hitStatus;

   always_ff @(posedge clk) begin
      if (!reset) begin
         PortOut <= '0;
      end else if (MemWrite && hitOut) begin
         PortOut <= WriteData;
      end
   end

   // Set has priority over the clear-on-read so a commit is never lost.
   always_ff @(posedge clk) begin
      if (!reset) begin
         changed <= 1'b0;
      end else if (commit) begin
         changed <= 1'b1;
      end else if (MemRead && hitStatus) begin
         changed <= 1'b0;
      end
   end

   always_comb begin
      statusWord                     = '0;
      statusWord[STATUS_BUSY_BIT]    = busy;
      statusWord[STATUS_CHANGED_BIT] = changed;
   end

   always_comb begin
      ReadData = '0;
      if (hitOut) begin
         ReadData = PortOut;
      end else if (hitIn) begin
         ReadData = {24'b0, stable};
      end else if (hitStatus) begin
         ReadData = statusWord;
      end
   end

endmodule : io_port_controller

// File: tb/tb_io_port_controller.sv
module tb_io_port_controller;

   localparam logic [31:0] IO_BASE = 32'h1001_0024;
   localparam logic [31:0] A_OUT    = IO_BASE;
   localparam logic [31:0] A_IN     = IO_BASE + 32'd4;
   localparam logic [31:0] A_STATUS = IO_BASE + 32'd8;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  PortIn;
   logic [31:0] ReadData;
   logic        IOHit;
   logic [31:0] PortOut;

   int checks = 0;
   int errors = 0;

   io_port_controller #(
      .IO_BASE        (IO_BASE),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .Address  (Address),
      .WriteData(WriteData),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .PortIn   (PortIn),
      .ReadData (ReadData),
      .IOHit    (IOHit),
      .PortOut  (PortOut)
   );

   always #5 clk = ~clk;

   // Advance past one rising edge; outputs are sampled 1ns after the edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; PortIn = 8'hFF; MemWrite = 1'b1; MemRead = 1'b0;
      Address = A_OUT; WriteData = 32'hCAFE_F00D;
      tick(3);
      checks++;
      if (PortOut !== 32'h0) begin
         errors++; $display("FAIL reset_portout: got %h expected %h", PortOut, 32'h0);
      end
      MemWrite = 1'b0; Address = A_STATUS; #1;
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL reset_status: got %h expected %h", ReadData, 32'h0);
      end
      reset = 1'b1; Address = A_IN;
      tick(6);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL reset_in_edge6: got %h expected %h", ReadData, 32'h0);
      end
      tick(1);
      checks++;
      if (ReadData !== 32'h0000_00FF) begin
         errors++; $display("FAIL reset_in_edge7: got %h expected %h", ReadData, 32'hFF);
      end
      // Return input to 0 and clear the sticky flag for the following tests.
      PortIn = 8'h00;
      tick(8);
      Address = A_STATUS; MemRead = 1'b1; #1;
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL reset_settle_status: got %h expected %h", ReadData, 32'h1);
      end
      tick(1);
      MemRead = 1'b0; #1;
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL reset_cleared: got %h expected %h", ReadData, 32'h0);
      end
   endtask

   task automatic test_output_write;
      Address = A_OUT; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1; #1;
      checks++;
      if (IOHit !== 1'b1) begin
         errors++; $display("FAIL write_iohit: got %b expected 1", IOHit);
      end
      tick(1);
      MemWrite = 1'b0; #1;
      checks++;
      if (PortOut !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_portout: got %h expected %h", PortOut, 32'hDEAD_BEEF);
      end
      checks++;
      if (ReadData !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_readback: got %h expected %h", ReadData, 32'hDEAD_BEEF);
      end
      Address = A_IN; WriteData = 32'h1234; MemWrite = 1'b1;
      tick(1);
      MemWrite = 1'b0;
      checks++;
      if (PortOut !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL write_in_ignored: got %h expected %h", PortOut, 32'hDEAD_BEEF);
      end
      Address = A_STATUS; WriteData = 32'hFFFF_FFFF; MemWrite = 1'b1;
      tick(1);
      MemWrite = 1'b0; #1;
      checks++;
      if (PortOut !== 32'hDEAD_BEEF || ReadData !== 32'h0) begin
         errors++; $display("FAIL write_status_ignored: got %h/%h expected %h/%h", PortOut, ReadData, 32'hDEAD_BEEF, 32'h0);
      end
   endtask

   task automatic test_glitch_reject;
      Address = A_STATUS; PortIn = 8'h5A;
      tick(3);
      PortIn = 8'h00;
      checks++;
      if (ReadData !== 32'h2) begin
         errors++; $display("FAIL glitch_busy_e3: got %h expected %h", ReadData, 32'h2);
      end
      tick(2);
      checks++;
      if (ReadData !== 32'h2) begin
         errors++; $display("FAIL glitch_busy_e5: got %h expected %h", ReadData, 32'h2);
      end
      tick(1);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL glitch_idle_e6: got %h expected %h", ReadData, 32'h0);
      end
      tick(4);
      Address = A_IN; #1;
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL glitch_in: got %h expected %h", ReadData, 32'h0);
      end
   endtask

   task automatic test_debounce_accept;
      Address = A_STATUS; PortIn = 8'h5A;
      tick(2);
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL accept_status_e2: got %h expected %h", ReadData, 32'h0);
      end
      for (int e = 3; e <= 6; e++) begin
         tick(1);
         checks++;
         if (ReadData !== 32'h2) begin
            errors++; $display("FAIL accept_busy_e%0d: got %h expected %h", e, ReadData, 32'h2);
         end
      end
      tick(1);
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL accept_status_e7: got %h expected %h", ReadData, 32'h1);
      end
      Address = A_IN; #1;
      checks++;
      if (ReadData !== 32'h5A) begin
         errors++; $display("FAIL accept_in: got %h expected %h", ReadData, 32'h5A);
      end
   endtask

   // Enters with changed=1 from the previous accept.
   task automatic test_clear_vs_set;
      Address = A_STATUS; PortIn = 8'h3C;
      tick(6);
      MemRead = 1'b1; #1;
      checks++;
      if (ReadData !== 32'h3) begin
         errors++; $display("FAIL clrset_old_value: got %h expected %h", ReadData, 32'h3);
      end
      tick(1);
      MemRead = 1'b0; #1;
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL clrset_set_wins: got %h expected %h", ReadData, 32'h1);
      end
      MemRead = 1'b1; #1;
      checks++;
      if (ReadData !== 32'h1) begin
         errors++; $display("FAIL clrset_second_read: got %h expected %h", ReadData, 32'h1);
      end
      tick(1);
      MemRead = 1'b0; #1;
      checks++;
      if (ReadData !== 32'h0) begin
         errors++; $display("FAIL clrset_cleared: got %h expected %h", ReadData, 32'h0);
      end
      Address = A_IN; #1;
      checks++;
      if (ReadData !== 32'h3C) begin
         errors++; $display("FAIL clrset_in: got %h expected %h", ReadData, 32'h3C);
      end
   endtask

   task automatic test_decode;
      logic [31:0] outside [2];
      outside[0] = IO_BASE + 32'd12;
      outside[1] = IO_BASE - 32'd4;
      for (int k = 0; k < 2; k++) begin
         Address = outside[k]; WriteData = 32'h0BAD_0BAD; MemWrite = 1'b1; MemRead = 1'b1; #1;
         checks++;
         if (IOHit !== 1'b0 || ReadData !== 32'h0) begin
            errors++; $display("FAIL decode_miss_%0d: got hit=%b data=%h expected hit=0 data=0", k, IOHit, ReadData);
         end
         tick(1);
         MemWrite = 1'b0; MemRead = 1'b0;
         checks++;
         if (PortOut !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL decode_portout_%0d: got %h expected %h", k, PortOut, 32'hDEAD_BEEF);
         end
      end
      Address = IO_BASE + 32'd7; #1;
      checks++;
      if (IOHit !== 1'b1 || ReadData !== 32'h3C) begin
         errors++; $display("FAIL decode_lowbits_in: got hit=%b data=%h expected hit=1 data=3c", IOHit, ReadData);
      end
      Address = IO_BASE + 32'd10; #1;
      checks++;
      if (IOHit !== 1'b1 || ReadData !== 32'h0) begin
         errors++; $display("FAIL decode_lowbits_status: got hit=%b data=%h expected hit=1 data=0", IOHit, ReadData);
      end
   endtask

   task automatic test_back_to_back;
      Address = A_OUT; WriteData = 32'h0123_4567; MemWrite = 1'b1; MemRead = 1'b1; #1;
      checks++;
      if (ReadData !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL b2b_read_old: got %h expected %h", ReadData, 32'hDEAD_BEEF);
      end
      tick(1);
      WriteData = 32'h89AB_CDEF;
      checks++;
      if (PortOut !== 32'h0123_4567) begin
         errors++; $display("FAIL b2b_first: got %h expected %h", PortOut, 32'h0123_4567);
      end
      tick(1);
      MemWrite = 1'b0; MemRead = 1'b0;
      checks++;
      if (PortOut !== 32'h89AB_CDEF) begin
         errors++; $display("FAIL b2b_second: got %h expected %h", PortOut, 32'h89AB_CDEF);
      end
   endtask

   initial begin
      reset = 1'b0; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = '0;
      #2;
      test_reset();
      test_output_write();
      test_glitch_reject();
      test_debounce_accept();
      test_clear_vs_set();
      test_decode();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_io_port_controller
